// File: rtl/pipe_adder.sv
// Pipelined ripple adder/subtractor: WIDTH bits split into STAGES segments, one
// segment added per stage, with a single global advance for valid/ready flow.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $fatal(1, "pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Stage inputs (_s), merged partial sums (_d) and stage registers (_q).
    logic [WIDTH-1:0] a_s   [STAGES];
    logic [WIDTH-1:0] b_s   [STAGES];
    logic [WIDTH-1:0] p_s   [STAGES];
    logic             c_s   [STAGES];
    logic             v_s   [STAGES];
    logic [SEG:0]     seg_s [STAGES];
    logic [WIDTH-1:0] p_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] p_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             ovf_d;
    logic             zero_d;
    logic             ovf_q;
    logic             zero_q;

    // A stall anywhere freezes the whole pipe, so no bubble is ever squeezed out.
    assign adv_s    = !v_q[LAST] || out_ready;
    assign in_ready = adv_s;
    assign b_eff_s  = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign a_s[k] = a;
            assign b_s[k] = b_eff_s;
            assign p_s[k] = {WIDTH{1'b0}};
            assign c_s[k] = sub;
            assign v_s[k] = in_valid;
        end else begin : g_body
            assign a_s[k] = a_q[k-1];
            assign b_s[k] = b_q[k-1];
            assign p_s[k] = p_q[k-1];
            assign c_s[k] = c_q[k-1];
            assign v_s[k] = v_q[k-1];
        end

        assign seg_s[k] = {1'b0, a_s[k][k*SEG +: SEG]}
                        + {1'b0, b_s[k][k*SEG +: SEG]}
                        + {{SEG{1'b0}}, c_s[k]};

        // Lower segments pass through untouched; this stage fills in its own slice.
        always_comb begin
            p_d[k]                = p_s[k];
            p_d[k][k*SEG +: SEG]  = seg_s[k][SEG-1:0];
        end

        // Stage register; data only loads with a valid beat so bubbles keep X out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                p_q[k] <= {WIDTH{1'b0}};
            end else if (adv_s) begin
                v_q[k] <= v_s[k];
                if (v_s[k]) begin
                    a_q[k] <= a_s[k];
                    b_q[k] <= b_s[k];
                    p_q[k] <= p_d[k];
                    c_q[k] <= seg_s[k][SEG];
                end
            end
        end
    end

    // Flags are evaluated from the completed sum entering the last stage.
    always_comb begin
        ovf_d  = (a_s[LAST][WIDTH-1] == b_s[LAST][WIDTH-1])
              && (p_d[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);
        zero_d = (p_d[LAST] == {WIDTH{1'b0}});
    end

    // Flag registers belong to the last stage and share its load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv_s && v_s[LAST]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = p_q[LAST];
    assign carry     = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: number of pipeline segments; also the latency in cycles.
REQ-003 WIDTH SHALL be a multiple of STAGES and STAGES SHALL be at least 1; elaboration SHALL fail otherwise; SEG = WIDTH/STAGES.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand beat present.
REQ-008 in_ready  out  1  block accepts the beat this cycle.
REQ-009 a  in  WIDTH  operand A.
REQ-010 b  in  WIDTH  operand B.
REQ-011 sub  in  1  0 = A+B, 1 = A-B.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 sum  out  WIDTH  result.
REQ-015 carry  out  1  unsigned carry out; for subtract, 1 = no borrow.
REQ-016 ovf  out  1  two's-complement signed overflow.
REQ-017 zero  out  1  sum equals 0.

Function
REQ-018 Subtract SHALL be computed as A + ~B + 1; the +1 is the carry-in to segment 0.
REQ-019 Pipeline stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] of A and the effective B plus the carry registered by stage k-1 (carry-in for k=0).
REQ-020 Stage k SHALL register its SEG-bit partial sum, its carry, and the not-yet-added upper operand bits; lower partial sums SHALL be forwarded unchanged.
REQ-021 Each stage SHALL hold a valid bit; the last stage's register SHALL drive sum, carry, ovf, zero and out_valid directly, with no combinational path from a/b.
REQ-022 ovf SHALL be (MSB of A == MSB of effective B) and (MSB of sum != MSB of A).
REQ-023 advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-024 When advance=1, every stage SHALL load from its predecessor on the clock edge, and stage 0 SHALL load in_valid plus the operands.
REQ-025 When advance=0, all stages SHALL hold contents and valid bits; result outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 A beat transfers in when in_valid && in_ready; a result transfers out when out_valid && out_ready.
REQ-027 Latency: a beat accepted at edge N with no stalls SHALL appear with out_valid=1 after edge N+STAGES-1.
REQ-028 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-029 Bubbles (in_valid=0 while advancing) SHALL propagate as invalid stages and SHALL NOT be compressed.
REQ-030 Result ordering SHALL equal acceptance order, with no loss or duplication under any stall pattern.
REQ-031 Simultaneous output transfer and input acceptance in one cycle SHALL be supported.
REQ-032 When STAGES=1, the single stage SHALL compute the full-width sum, with latency 1 cycle.
REQ-033 When out_valid=0, sum, carry, ovf and zero are don't-care but SHALL be X-free.

Reset
REQ-034 rst_n=0 SHALL immediately clear all valid bits and all data, carry and flag registers to 0, asynchronously and regardless of clk.
REQ-035 During reset, out_valid=0, in_ready=1, sum=0, carry=0, ovf=0, zero=0.
REQ-036 In-flight beats SHALL be discarded on reset, and none SHALL appear after deassertion.
REQ-037 Reset deassertion SHALL be synchronous to clk by the integrator; the first beat SHALL be accepted on the first edge after deassertion.

Verification (WIDTH=32, STAGES=4)
REQ-038 Add 0xFFFFFFFF + 0x00000001, out_ready=1 -> after 4 edges: sum=0x00000000, carry=1, zero=1, ovf=0; this exercises carry through all segments.
REQ-039 Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry=0, ovf=1, zero=0.
REQ-040 Subtract 5 - 7 -> sum=0xFFFFFFFE, carry=0, ovf=0; subtract 7 - 5 -> sum=2, carry=1.
REQ-041 Six back-to-back beats (i+1)+(i+1), i=0..5, with out_ready=0 from the cycle the first result appears for 3 cycles -> in_ready=0 and sum held at 2 during the stall; results then emerge in order 2,4,6,8,10,12.
REQ-042 Assert rst_n=0 mid-cycle with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release, no stale results appear and a new beat 1+1 returns 2 after 4 edges.
REQ-043 Alternating bubbles (in_valid toggling) with random out_ready, compared against a reference-model scoreboard -> zero mismatches over 10000 beats.
